// File: rtl/acc_pkg.sv
// Shared types and constants for the batch accumulator.
package acc_pkg;

  localparam int unsigned ACC_W = 8;

  // Batch controller states: collecting operands, or presenting a finished sum.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Saturating select used when the accumulator is configured to clamp on overflow.
  function automatic logic [ACC_W-1:0] clamp_on_carry(input logic [ACC_W-1:0] sum,
                                                      input logic             carry);
    return carry ? {ACC_W{1'b1}} : sum;
  endfunction

endpackage

// File: rtl/accum_8b_if.sv
// Operand-in / batch-result-out handshake bundle for accum_8b.
interface accum_8b_if;
  import acc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_carry;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );

endinterface

// File: rtl/full_adder_8b.sv
// 8-bit ripple-carry adder with carry-in and carry-out.
module full_adder_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co8
);

  logic [8:0] c;

  // Ripple the carry through eight full-adder cells.
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co8 = c[8];
  end

endmodule

// File: rtl/accum_8b.sv
// Batch accumulator: sums N_OPS operands through one full_adder_8b and holds
// the sum plus a sticky overflow flag until the consumer takes it.
// Build option: define ACC_SATURATE_EN to clamp the running sum at 8'hFF on
// overflow instead of wrapping modulo 256.
module accum_8b
  import acc_pkg::*;
#(
  parameter int unsigned N_OPS = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  accum_8b_if.slave   bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;

  logic [ACC_W-1:0]   add_s;
  logic               add_co;
  logic               accept_c;
  logic               last_c;

  full_adder_8b u_add (
    .a   (acc_q),
    .b   (bus.in_data),
    .ci  (1'b0),
    .s   (add_s),
    .co8 (add_co)
  );

  // Handshake view of the state; outputs come straight from flops.
  assign bus.in_ready  = ~rst & (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = carry_q;

  assign accept_c = bus.in_valid & bus.in_ready;
  assign last_c   = (cnt_q == CNT_W'(N_OPS - 1));

  // Next-state: accumulate accepted operands, close the batch, release on take.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_c) begin
`ifdef ACC_SATURATE_EN
          acc_d = clamp_on_carry(add_s, add_co);
`else
          acc_d = add_s;
`endif
          carry_d = carry_q | add_co;
          if (last_c) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          carry_d = 1'b0;
          state_d = ST_ACCUM;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_accum_8b.sv
// Self-checking bench for accum_8b: a 4-operand and a 1-operand instance share
// one stimulus stream, each checked every cycle against a batch-level model.
module tb_accum_8b;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  accum_8b_if bus4 ();
  accum_8b_if bus1 ();

  accum_8b #(.N_OPS(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  accum_8b #(.N_OPS(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Model: operands accepted so far in the current batch, and whether a
  // finished batch is waiting for the consumer.
  int unsigned nops [2] = '{4, 1};
  int          ops  [2][256];
  int          len  [2];
  bit          pend [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Sum the operands of the current batch the way the block defines it.
  function automatic void fold(input int idx, output logic [7:0] s, output logic c);
    int acc = 0;
    int t;
    c = 1'b0;
    for (int k = 0; k < len[idx]; k++) begin
      t = acc + ops[idx][k];
      if (t > 255) begin
        c = 1'b1;
`ifdef ACC_SATURATE_EN
        acc = 255;
`else
        acc = t - 256;
`endif
      end else begin
        acc = t;
      end
    end
    s = 8'(acc);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check both DUTs.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit ordy);
    logic [7:0] es;
    logic       ec;
    rst            = r;
    bus4.in_valid  = v;
    bus4.in_data   = d;
    bus4.out_ready = ordy;
    bus1.in_valid  = v;
    bus1.in_data   = d;
    bus1.out_ready = ordy;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        len[i]  = 0;
        pend[i] = 1'b0;
      end else if (pend[i]) begin
        if (ordy) begin
          pend[i] = 1'b0;
          len[i]  = 0;
        end
      end else if (v) begin
        ops[i][len[i]] = int'(d);
        len[i]++;
        if (len[i] == int'(nops[i])) pend[i] = 1'b1;
      end
    end
    #1;
    fold(0, es, ec);
    check("n4_in_ready",  {7'b0, bus4.in_ready},  {7'b0, (!r && !pend[0])});
    check("n4_out_valid", {7'b0, bus4.out_valid}, {7'b0, pend[0]});
    check("n4_out_sum",   bus4.out_sum,           es);
    check("n4_out_carry", {7'b0, bus4.out_carry}, {7'b0, ec});
    fold(1, es, ec);
    check("n1_in_ready",  {7'b0, bus1.in_ready},  {7'b0, (!r && !pend[1])});
    check("n1_out_valid", {7'b0, bus1.out_valid}, {7'b0, pend[1]});
    check("n1_out_sum",   bus1.out_sum,           es);
    check("n1_out_carry", {7'b0, bus1.out_carry}, {7'b0, ec});
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] bub_d [7] = '{8'd5, 8'd9, 8'd9, 8'd5, 8'd9, 8'd5, 8'd5};
    bit         bub_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    len  = '{0, 0};
    pend = '{1'b0, 1'b0};

    // Reset, including in_ready low while rst is held.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h55, 1'b1);

    // Plain batch, consumer always ready.
    cycle(1'b0, 1'b1, 8'd10, 1'b1);
    cycle(1'b0, 1'b1, 8'd20, 1'b1);
    cycle(1'b0, 1'b1, 8'd30, 1'b1);
    check("t1_valid_before_last", {7'b0, bus4.out_valid}, 8'h00);
    cycle(1'b0, 1'b1, 8'd40, 1'b1);
    check("t1_sum",   bus4.out_sum, 8'h64);
    check("t1_carry", {7'b0, bus4.out_carry}, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_valid_one_cycle", {7'b0, bus4.out_valid}, 8'h00);

    // Overflow batch; the consumer then stalls while operands keep arriving.
    cycle(1'b0, 1'b1, 8'h80, 1'b0);
    cycle(1'b0, 1'b1, 8'h80, 1'b0);
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
`ifdef ACC_SATURATE_EN
    check("t2_sum", bus4.out_sum, 8'hFF);
`else
    check("t2_sum", bus4.out_sum, 8'h02);
`endif
    check("t2_carry", {7'b0, bus4.out_carry}, 8'h01);
    held = bus4.out_sum;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, k[0] == 1'b0, 8'h33, 1'b0);
      check("t3_sum_stable", bus4.out_sum, held);
      check("t3_in_ready_low", {7'b0, bus4.in_ready}, 8'h00);
    end
    cycle(1'b0, 1'b1, 8'h33, 1'b1);
    check("t3_in_ready_after_take", {7'b0, bus4.in_ready}, 8'h01);

    // Reset in the middle of a batch.
    cycle(1'b0, 1'b1, 8'd50, 1'b1);
    cycle(1'b0, 1'b1, 8'd60, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'd1, 1'b0);
    cycle(1'b0, 1'b1, 8'd2, 1'b0);
    cycle(1'b0, 1'b1, 8'd3, 1'b0);
    cycle(1'b0, 1'b1, 8'd4, 1'b0);
    check("t4_sum",   bus4.out_sum, 8'h0A);
    check("t4_carry", {7'b0, bus4.out_carry}, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Bubbles between operands.
    for (int k = 0; k < 7; k++) cycle(1'b0, bub_v[k], bub_d[k], 1'b0);
    check("t5_valid", {7'b0, bus4.out_valid}, 8'h01);
    check("t5_sum",   bus4.out_sum, 8'h14);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Single-operand batches.
    cycle(1'b0, 1'b1, 8'hC3, 1'b0);
    check("t6_valid", {7'b0, bus1.out_valid}, 8'h01);
    check("t6_sum",   bus1.out_sum, 8'hC3);
    check("t6_carry", {7'b0, bus1.out_carry}, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7,
            8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
